aes_round_key_reader: RTL and testbench

- Reader end of the byte-serial round-key stream produced by the 8-bit key expansion unit.
- Captures all NR+1 round keys, 16 bytes each, MSB byte first, into a local 8-bit-wide buffer.
- Replays the keys byte-serially in reverse round order (round NR down to 0) to the byte-serial inverse cipher over a valid/ready handshake.
- Keys are retained, so consecutive ciphertext blocks replay without re-expansion.

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_round_key_reader_if.sv | 38 +++
 rtl/aes_key_byte_ram.sv | 35 +++
 rtl/aes_round_key_reader.sv | 169 ++++++++++++++++
 tb/tb_aes_round_key_reader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-buffer definitions: round/key-size constants, reader state
// encoding and the round/byte to buffer-address mapping.
package aes_pkg;

    localparam int unsigned AES_NR        = 10;
    localparam int unsigned AES_KEY_BYTES = 16;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_READY   = 2'd1,
        ST_READING = 2'd2
    } key_state_e;

    // Round k, byte b lives at k*16+b; byte 0 is key bits 127:120.
    function automatic int unsigned aes_key_addr(input logic [3:0] k, input logic [3:0] b);
        return 32'(k) * AES_KEY_BYTES + 32'(b);
    endfunction

endpackage

// File: rtl/aes_round_key_reader_if.sv
// Write/replay bus of the round-key reader. rd_dir exists only when
// AES_KEYREAD_FWD_EN is defined.
interface aes_round_key_reader_if #(
    parameter int unsigned DW = 8
);
    logic          clear;
    logic          wr_valid;
    logic [DW-1:0] wr_byte;
    logic          rd_start;
`ifdef AES_KEYREAD_FWD_EN
    logic          rd_dir;
`endif
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_byte;
    logic [3:0]    rd_round;
    logic          rd_last;
    logic          keys_ready;
    logic          busy;
    logic          wr_err;

    modport slave (
        input  clear, wr_valid, wr_byte, rd_start, rd_ready,
`ifdef AES_KEYREAD_FWD_EN
        input  rd_dir,
`endif
        output rd_valid, rd_byte, rd_round, rd_last, keys_ready, busy, wr_err
    );

    modport master (
        output clear, wr_valid, wr_byte, rd_start, rd_ready,
`ifdef AES_KEYREAD_FWD_EN
        output rd_dir,
`endif
        input  rd_valid, rd_byte, rd_round, rd_last, keys_ready, busy, wr_err
    );

endinterface

// File: rtl/aes_key_byte_ram.sv
// Round-key byte buffer: one write port, one registered read port whose
// output holds while i_re is low.
module aes_key_byte_ram #(
    parameter int unsigned DEPTH = 176,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register doubles as the replay output byte, so it is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/aes_round_key_reader.sv
// Captures the byte-serial AES key schedule and replays it round NR..0
// (or 0..NR when AES_KEYREAD_FWD_EN is defined and rd_dir=1).
module aes_round_key_reader
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR,
    parameter int unsigned DW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    aes_round_key_reader_if.slave   bus
);

    localparam int unsigned DEPTH = (NR + 1) * AES_KEY_BYTES;
    localparam int unsigned AW    = $clog2(DEPTH);

    key_state_e    r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [3:0]    r_rd_round;
    logic [3:0]    r_rd_idx;
    logic          r_fwd;
    logic          r_rd_valid;
    logic          r_rd_last;
    logic          r_keys_ready;
    logic          r_busy;
    logic          r_wr_err;

    key_state_e    w_state_nxt;
    logic [AW-1:0] w_wr_ptr_nxt;
    logic [3:0]    w_round_nxt;
    logic [3:0]    w_idx_nxt;
    logic          w_fwd_nxt;
    logic          w_valid_nxt;
    logic          w_last_nxt;
    logic          w_wr_err_nxt;
    logic          w_ram_we;
    logic          w_ram_re;
    logic [AW-1:0] w_ram_raddr;
    logic [DW-1:0] w_ram_rdata;
    logic          w_dir;
    logic          w_hs;

`ifdef AES_KEYREAD_FWD_EN
    assign w_dir = bus.rd_dir;
`else
    assign w_dir = 1'b0;
`endif

    assign w_hs        = r_rd_valid && bus.rd_ready;
    assign w_ram_raddr = AW'(aes_key_addr(w_round_nxt, w_idx_nxt));

    aes_key_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wr_byte),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // Next state, cursors and output values; clear overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_round_nxt  = r_rd_round;
        w_idx_nxt    = r_rd_idx;
        w_fwd_nxt    = r_fwd;
        w_valid_nxt  = r_rd_valid;
        w_last_nxt   = r_rd_last;
        w_wr_err_nxt = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_re     = 1'b0;

        if (bus.clear) begin
            w_state_nxt  = ST_EMPTY;
            w_wr_ptr_nxt = '0;
            w_valid_nxt  = 1'b0;
            w_last_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (bus.wr_valid) begin
                        w_ram_we     = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                        if (r_wr_ptr == AW'(DEPTH - 1)) begin
                            w_state_nxt = ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    w_wr_err_nxt = bus.wr_valid;
                    if (bus.rd_start) begin
                        w_state_nxt = ST_READING;
                        w_fwd_nxt   = w_dir;
                        w_round_nxt = w_dir ? 4'd0 : 4'(NR);
                        w_idx_nxt   = 4'd0;
                        w_ram_re    = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = 1'b0;
                    end
                end
                ST_READING: begin
                    w_wr_err_nxt = bus.wr_valid;
                    if (w_hs) begin
                        if (r_rd_last) begin
                            w_state_nxt = ST_READY;
                            w_valid_nxt = 1'b0;
                            w_last_nxt  = 1'b0;
                        end else begin
                            if (r_rd_idx == 4'd15) begin
                                w_idx_nxt   = 4'd0;
                                w_round_nxt = r_fwd ? (r_rd_round + 4'd1) : (r_rd_round - 4'd1);
                            end else begin
                                w_idx_nxt = r_rd_idx + 4'd1;
                            end
                            w_ram_re   = 1'b1;
                            w_last_nxt = (w_idx_nxt == 4'd15) &&
                                         (w_round_nxt == (r_fwd ? 4'(NR) : 4'd0));
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_wr_ptr     <= '0;
            r_rd_round   <= 4'd0;
            r_rd_idx     <= 4'd0;
            r_fwd        <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_keys_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_wr_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_round   <= w_round_nxt;
            r_rd_idx     <= w_idx_nxt;
            r_fwd        <= w_fwd_nxt;
            r_rd_valid   <= w_valid_nxt;
            r_rd_last    <= w_last_nxt;
            r_keys_ready <= (w_state_nxt != ST_EMPTY);
            r_busy       <= (w_state_nxt == ST_READING);
            r_wr_err     <= w_wr_err_nxt;
        end
    end

    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_byte    = w_ram_rdata;
    assign bus.rd_round   = r_rd_round;
    assign bus.rd_last    = r_rd_last;
    assign bus.keys_ready = r_keys_ready;
    assign bus.busy       = r_busy;
    assign bus.wr_err     = r_wr_err;

endmodule

// File: tb/tb_aes_round_key_reader.sv
// Scoreboard bench for aes_round_key_reader using the FIPS-197 example key;
// the schedule is expanded locally from a computed S-box.
module tb_aes_round_key_reader;

    localparam int unsigned NR     = 10;
    localparam int unsigned NBYTES = (NR + 1) * 16;

    typedef struct packed {
        logic [7:0] b;
        logic [3:0] r;
        logic       l;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    aes_round_key_reader_if #(.DW(8)) bus ();

    aes_round_key_reader #(.NR(NR), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    logic [7:0] ks [NBYTES];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = rcon[7] ? ((rcon << 1) ^ 8'h1b) : (rcon << 1);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < NBYTES; j++) ks[j] = w[j/4][31-8*(j%4) -: 8];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_keys(input logic dir, input int n);
        int rnd;
        int b;
        for (int j = 0; j < n; j++) begin
            rnd = dir ? (j / 16) : (NR - j / 16);
            b   = j % 16;
            q.push_back('{b: ks[rnd*16+b], r: 4'(rnd), l: (j == NBYTES - 1)});
        end
    endtask

    // Handshake monitor: pops the scoreboard and checks stall stability.
    logic prev_stall = 1'b0;
    exp_t prev;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rd_valid) begin
            if (prev_stall) begin
                chk("hold_byte", 32'(bus.rd_byte), 32'(prev.b));
                chk("hold_round", 32'(bus.rd_round), 32'(prev.r));
            end
            if (bus.rd_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_byte", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("rd_byte", 32'(bus.rd_byte), 32'(e.b));
                    chk("rd_round", 32'(bus.rd_round), 32'(e.r));
                    chk("rd_last", 32'(bus.rd_last), 32'(e.l));
                end
            end
            prev_stall = !bus.rd_ready;
            prev       = '{b: bus.rd_byte, r: bus.rd_round, l: bus.rd_last};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic fill(input logic start_on_last);
        for (int i = 0; i < NBYTES; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_byte  = ks[i];
            bus.rd_start = start_on_last && (i == NBYTES - 1);
            step();
            if (i == NBYTES - 2) chk("kr_before_full", 32'(bus.keys_ready), 32'(0));
        end
        bus.wr_valid = 1'b0;
        bus.rd_start = 1'b0;
        chk("kr_after_full", 32'(bus.keys_ready), 32'(1));
    endtask

    task automatic start_replay(input logic dir);
`ifdef AES_KEYREAD_FWD_EN
        bus.rd_dir = dir;
`endif
        bus.rd_ready = 1'b1;
        bus.rd_start = 1'b1;
        step();
        bus.rd_start = 1'b0;
        chk("start_latency", 32'(bus.rd_valid), 32'(1));
        chk("busy_replay", 32'(bus.busy), 32'(1));
    endtask

    task automatic drain(input int mode);
        int cyc = 0;
        while (q.size() > 0 && cyc < 2000) begin
            bus.rd_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            step();
            cyc++;
        end
        if (q.size() != 0) begin
            chk("replay_timeout", 32'(q.size()), 32'(0));
            q.delete();
        end
        bus.rd_ready = 1'b0;
    endtask

    task automatic replay(input int mode, input logic dir);
        push_keys(dir, NBYTES);
        start_replay(dir);
        drain(mode);
        chk("busy_done", 32'(bus.busy), 32'(0));
        chk("valid_done", 32'(bus.rd_valid), 32'(0));
        chk("keys_kept", 32'(bus.keys_ready), 32'(1));
    endtask

    initial begin
        expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("ks_r10_b0", 32'(ks[160]), 32'h d0);
        chk("ks_r10_b15", 32'(ks[175]), 32'h a6);
        chk("ks_r0_b15", 32'(ks[15]), 32'h 3c);

        rst          = 1'b1;
        bus.clear    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_byte  = 8'h00;
        bus.rd_start = 1'b0;
        bus.rd_ready = 1'b0;
`ifdef AES_KEYREAD_FWD_EN
        bus.rd_dir   = 1'b0;
`endif
        repeat (3) step();
        chk("rst_valid", 32'(bus.rd_valid), 32'(0));
        chk("rst_byte", 32'(bus.rd_byte), 32'(0));
        chk("rst_round", 32'(bus.rd_round), 32'(0));
        chk("rst_last", 32'(bus.rd_last), 32'(0));
        chk("rst_keys_ready", 32'(bus.keys_ready), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_wr_err", 32'(bus.wr_err), 32'(0));
        rst = 1'b0;
        step();

        // rd_start while empty does nothing
        bus.rd_start = 1'b1;
        step();
        bus.rd_start = 1'b0;
        chk("empty_start_valid", 32'(bus.rd_valid), 32'(0));
        chk("empty_start_busy", 32'(bus.busy), 32'(0));

        fill(1'b0);
        replay(0, 1'b0);
        replay(1, 1'b0);

        // write while READY is rejected
        bus.wr_valid = 1'b1;
        bus.wr_byte  = 8'h55;
        step();
        bus.wr_valid = 1'b0;
        chk("wr_err_pulse", 32'(bus.wr_err), 32'(1));
        step();
        chk("wr_err_clear", 32'(bus.wr_err), 32'(0));
        chk("wr_err_kr", 32'(bus.keys_ready), 32'(1));
        replay(0, 1'b0);

        // clear at byte 40 of a replay, with a coincident write
        push_keys(1'b0, 40);
        start_replay(1'b0);
        drain(0);
        bus.clear    = 1'b1;
        bus.wr_valid = 1'b1;
        step();
        bus.clear    = 1'b0;
        bus.wr_valid = 1'b0;
        chk("clr_valid", 32'(bus.rd_valid), 32'(0));
        chk("clr_busy", 32'(bus.busy), 32'(0));
        chk("clr_keys_ready", 32'(bus.keys_ready), 32'(0));
        chk("clr_wr_err", 32'(bus.wr_err), 32'(0));
        bus.rd_ready = 1'b1;
        bus.rd_start = 1'b1;
        step();
        bus.rd_start = 1'b0;
        repeat (3) step();
        chk("clr_start_valid", 32'(bus.rd_valid), 32'(0));
        bus.rd_ready = 1'b0;

        // rd_start coinciding with the final fill write is ignored
        fill(1'b1);
        chk("fill_start_valid", 32'(bus.rd_valid), 32'(0));
        chk("fill_start_busy", 32'(bus.busy), 32'(0));
        step();
        replay(0, 1'b0);

`ifdef AES_KEYREAD_FWD_EN
        replay(0, 1'b1);
        replay(1, 1'b0);
`endif

        // reset in the middle of a replay
        push_keys(1'b0, 5);
        start_replay(1'b0);
        drain(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_byte", 32'(bus.rd_byte), 32'(0));
        chk("mrst_round", 32'(bus.rd_round), 32'(0));
        chk("mrst_valid", 32'(bus.rd_valid), 32'(0));
        chk("mrst_busy", 32'(bus.busy), 32'(0));
        chk("mrst_keys_ready", 32'(bus.keys_ready), 32'(0));
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
